// File: rtl/conv2d_4x4_s2_layer_pkg.sv
// Shared fixed-point constants, pipeline tag type and saturation helper for the
// strided 4x4 convolution layer.
package conv2d_4x4_s2_layer_pkg;

  localparam int unsigned FRAC_BITS_DEFAULT = 8;
  localparam int unsigned ACC_WIDTH         = 36;
  localparam int unsigned K                 = 4;
  localparam int unsigned TAPS              = K * K;

  typedef struct packed {
    logic valid;
    logic last;
  } pipe_tag_t;

  function automatic logic [15:0] sat16(input logic signed [ACC_WIDTH-1:0] val);
    if (val > 36'sd32767)
      return 16'h7FFF;
    else if (val < -36'sd32768)
      return 16'h8000;
    else
      return val[15:0];
  endfunction

endpackage

// File: rtl/conv2d_4x4_s2_layer_if.sv
// Pixel stream in / result stream out of the strided convolution layer.
interface conv2d_4x4_s2_layer_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  frame_done;

  modport master (output valid_in, data_in, input valid_out, data_out, frame_done);
  modport slave  (input valid_in, data_in, output valid_out, data_out, frame_done);
endinterface

// File: rtl/conv2d_4x4_s2_layer_line_buffer.sv
// Shift-enabled delay line of DEPTH words; dout is the word pushed DEPTH shifts ago.
module conv2d_4x4_s2_layer_line_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH*WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (en) sr <= {sr[(DEPTH-1)*WIDTH-1:0], din};
  end

  assign dout = sr[DEPTH*WIDTH-1 -: WIDTH];
endmodule

// File: rtl/conv2d_4x4_s2_layer.sv
// Streaming 4x4 stride-2 convolution (correlation, no padding) over one
// IN_WIDTH x IN_WIDTH frame; fixed 3-cycle latency from completing pixel.
module conv2d_4x4_s2_layer
  import conv2d_4x4_s2_layer_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv2d_4x4_s2_layer_if.slave  strm,
  input  logic [DATA_WIDTH-1:0] w0,
  input  logic [DATA_WIDTH-1:0] w1,
  input  logic [DATA_WIDTH-1:0] w2,
  input  logic [DATA_WIDTH-1:0] w3,
  input  logic [DATA_WIDTH-1:0] w4,
  input  logic [DATA_WIDTH-1:0] w5,
  input  logic [DATA_WIDTH-1:0] w6,
  input  logic [DATA_WIDTH-1:0] w7,
  input  logic [DATA_WIDTH-1:0] w8,
  input  logic [DATA_WIDTH-1:0] w9,
  input  logic [DATA_WIDTH-1:0] w10,
  input  logic [DATA_WIDTH-1:0] w11,
  input  logic [DATA_WIDTH-1:0] w12,
  input  logic [DATA_WIDTH-1:0] w13,
  input  logic [DATA_WIDTH-1:0] w14,
  input  logic [DATA_WIDTH-1:0] w15,
  input  logic [DATA_WIDTH-1:0] bias
);
  localparam int unsigned CW = $clog2(IN_WIDTH);
  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic [CW-1:0]               col, row;
  logic                        last_col, last_row, emit;
  logic [DATA_WIDTH-1:0]       lb_out [3];
  logic [DATA_WIDTH-1:0]       win    [K][K];
  logic [DATA_WIDTH-1:0]       snap   [K][K];
  logic [DATA_WIDTH-1:0]       w      [TAPS];
  logic signed [PW-1:0]        prod   [TAPS];
  logic signed [ACC_WIDTH-1:0] acc, acc_shr;
  pipe_tag_t                   tag_win, tag_cap, tag_mul;

  assign w = '{w0, w1, w2, w3, w4, w5, w6, w7, w8, w9, w10, w11, w12, w13, w14, w15};

  assign last_col = (col == CW'(IN_WIDTH - 1));
  assign last_row = (row == CW'(IN_WIDTH - 1));
  assign emit     = (row >= CW'(3)) && (col >= CW'(3)) && row[0] && col[0];

  conv2d_4x4_s2_layer_line_buffer #(.DEPTH(IN_WIDTH), .WIDTH(DATA_WIDTH)) u_lb0 (
    .clk(clk), .en(strm.valid_in), .din(strm.data_in), .dout(lb_out[0])
  );
  conv2d_4x4_s2_layer_line_buffer #(.DEPTH(IN_WIDTH), .WIDTH(DATA_WIDTH)) u_lb1 (
    .clk(clk), .en(strm.valid_in), .din(lb_out[0]), .dout(lb_out[1])
  );
  conv2d_4x4_s2_layer_line_buffer #(.DEPTH(IN_WIDTH), .WIDTH(DATA_WIDTH)) u_lb2 (
    .clk(clk), .en(strm.valid_in), .din(lb_out[1]), .dout(lb_out[2])
  );

  // Row 0 is the oldest image row, column K-1 the newest pixel.
  always_ff @(posedge clk) begin
    if (strm.valid_in) begin
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K - 1; c++)
          win[r][c] <= win[r][c+1];
      win[0][K-1] <= lb_out[2];
      win[1][K-1] <= lb_out[1];
      win[2][K-1] <= lb_out[0];
      win[3][K-1] <= strm.data_in;
    end
  end

  // Snapshot frees the window to keep shifting on back-to-back pixels.
  always_ff @(posedge clk) begin
    if (tag_win.valid) snap <= win;
    if (tag_cap.valid) begin
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++)
          prod[r*K+c] <= PW'($signed(snap[r][c])) * PW'($signed(w[r*K+c]));
    end
  end

  always_comb begin
    acc = ACC_WIDTH'($signed(bias)) <<< FRAC_BITS;
    for (int unsigned i = 0; i < TAPS; i++)
      acc = acc + ACC_WIDTH'(prod[i]);
    acc_shr = acc >>> FRAC_BITS;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col             <= '0;
      row             <= '0;
      tag_win         <= '0;
      tag_cap         <= '0;
      tag_mul         <= '0;
      strm.valid_out  <= 1'b0;
      strm.data_out   <= '0;
      strm.frame_done <= 1'b0;
    end else begin
      if (strm.valid_in) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      tag_win.valid   <= strm.valid_in && emit;
      tag_win.last    <= last_col && last_row;
      tag_cap         <= tag_win;
      tag_mul         <= tag_cap;
      strm.valid_out  <= tag_mul.valid;
      strm.frame_done <= tag_mul.valid && tag_mul.last;
      if (tag_mul.valid) strm.data_out <= sat16(acc_shr);
    end
  end

endmodule
